// File: rtl/spi_pkg.sv
// Shared types and constants for the burst SPI slave.
// The error-flag feature is enabled by defining SPI_SLAVE_ERR_EN.
package spi_pkg;

   // Transfer state of the slave
   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StShift
   } spi_state_e;

   // SPI mode constants, encoded as {CPOL, CPHA}
   localparam logic [1:0] SpiMode0 = 2'b00;
   localparam logic [1:0] SpiMode1 = 2'b01;
   localparam logic [1:0] SpiMode2 = 2'b10;
   localparam logic [1:0] SpiMode3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall strobes
// in the i_clock domain. Strobes are one i_clock cycle wide.
module spi_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter bit          RESET_VAL   = 1'b0
) (
   input  logic i_clock,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Synchroniser chain plus one delayed copy for edge detection
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign o_level = sync_q[SYNC_STAGES-1];
   assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_burst.sv
// Parametrised SPI slave with multi-word bursts, all four CPOL/CPHA modes,
// selectable bit order and a valid/ready TX holding register.
// Optional sticky error flags are built when SPI_SLAVE_ERR_EN is defined.
module spi_slave_burst
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter bit          CPOL        = 1'b0,
   parameter bit          CPHA        = 1'b0,
   parameter bit          LSB_FIRST   = 1'b1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              i_clock,
   input  logic              i_rst_n,
   input  logic              i_spi_clk,
   input  logic              i_spi_ss,
   input  logic              i_spi_mosi,
   output logic              o_spi_miso,
   output logic              o_spi_miso_oe,
   input  logic [DATA_W-1:0] i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
`ifdef SPI_SLAVE_ERR_EN
   input  logic              i_err_clr,
   output logic              o_err_underrun,
   output logic              o_err_frame,
`endif
   output logic [DATA_W-1:0] o_rx_data,
   output logic              o_rx_valid,
   output logic              o_busy
);

   localparam int unsigned     CntW         = $clog2(DATA_W);
   localparam logic [CntW-1:0] LastBit      = CntW'(DATA_W - 1);
   localparam logic [1:0]      Mode         = {CPOL, CPHA};
   localparam bit              SampleOnLead = (Mode == SpiMode0) || (Mode == SpiMode2);

   // Wire position of the k-th transferred bit within a word
   function automatic logic [CntW-1:0] bit_idx(input logic [CntW-1:0] k);
      return LSB_FIRST ? k : LastBit - k;
   endfunction

   spi_state_e              state_q, state_d;
   logic                    armed_q, armed_d;
   logic [CntW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]       rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0]       rx_data_q, rx_data_d;
   logic                    rx_valid_q, rx_valid_d;
   logic [DATA_W-1:0]       tx_word_q, tx_word_d;
   logic                    miso_q, miso_d;
   logic [DATA_W-1:0]       hold_q, hold_d;
   logic                    hold_full_q, hold_full_d;
   logic [SYNC_STAGES-1:0]  mosi_sync_q;

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic ss_lvl, ss_rise, ss_fall;
   logic sclk_edge, lead_stb, trail_stb, sample_stb, shift_stb;
   logic mosi_bit, load, tx_wr;
   logic [DATA_W-1:0] rx_next, load_word;

   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (CPOL)
   ) u_sclk_sync (
      .i_clock (i_clock),
      .i_rst_n (i_rst_n),
      .i_async (i_spi_clk),
      .o_level (sclk_lvl),
      .o_rise  (sclk_rise),
      .o_fall  (sclk_fall)
   );

   // SS resets low so that a select already active at reset release never
   // arms the block until it has been seen high.
   spi_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_VAL   (1'b0)
   ) u_ss_sync (
      .i_clock (i_clock),
      .i_rst_n (i_rst_n),
      .i_async (i_spi_ss),
      .o_level (ss_lvl),
      .o_rise  (ss_rise),
      .o_fall  (ss_fall)
   );

   // MOSI synchroniser, same depth as SCLK so data and strobe stay aligned
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         mosi_sync_q <= '0;
      end else begin
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      end
   end

   // Leading edge leaves the idle level, trailing edge returns to it
   assign sclk_edge  = sclk_rise | sclk_fall;
   assign lead_stb   = sclk_edge & (sclk_lvl != CPOL);
   assign trail_stb  = sclk_edge & (sclk_lvl == CPOL);
   assign sample_stb = SampleOnLead ? lead_stb : trail_stb;
   assign shift_stb  = SampleOnLead ? trail_stb : lead_stb;
   assign mosi_bit   = mosi_sync_q[SYNC_STAGES-1];

   assign rx_next = LSB_FIRST ? {mosi_bit, rx_shift_q[DATA_W-1:1]}
                              : {rx_shift_q[DATA_W-2:0], mosi_bit};

   // TX word fetches happen on LOAD and on every word boundary
   assign load = ~ss_rise & ((state_q == StLoad) ||
                 ((state_q == StShift) && sample_stb && (bit_cnt_q == LastBit)));
   assign load_word  = hold_full_q ? hold_q : '0;
   // A load frees the holding register in the same cycle it can be refilled
   assign o_tx_ready = ~hold_full_q | load;
   assign tx_wr      = i_tx_valid & o_tx_ready;

   // Next-state: FSM, bit counter, shift registers and holding register
   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q | ss_lvl;
      bit_cnt_d   = bit_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      tx_word_d   = tx_word_q;
      miso_d      = miso_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;

      if (ss_rise) begin
         // Partial words are dropped here
         state_d   = StIdle;
         bit_cnt_d = '0;
         miso_d    = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ss_fall && armed_q) state_d = StLoad;
            end
            StLoad: begin
               state_d = StShift;
               if (!CPHA) miso_d = load_word[bit_idx('0)];
            end
            StShift: begin
               if (sample_stb) begin
                  rx_shift_d = rx_next;
                  if (bit_cnt_q == LastBit) begin
                     bit_cnt_d  = '0;
                     rx_data_d  = rx_next;
                     rx_valid_d = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CntW'(1);
                  end
               end
               // Counter already points at the bit to present next
               if (shift_stb) miso_d = tx_word_q[bit_idx(bit_cnt_q)];
            end
            default: state_d = StIdle;
         endcase
      end

      if (load) begin
         tx_word_d   = load_word;
         hold_full_d = 1'b0;
      end
      if (tx_wr) begin
         hold_d      = i_tx_data;
         hold_full_d = 1'b1;
      end
   end

   // State register with synchronous reset
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         armed_q     <= 1'b0;
         bit_cnt_q   <= '0;
         rx_shift_q  <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         tx_word_q   <= '0;
         miso_q      <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_shift_q  <= rx_shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         tx_word_q   <= tx_word_d;
         miso_q      <= miso_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
      end
   end

`ifdef SPI_SLAVE_ERR_EN
   logic err_underrun_q, err_frame_q;

   // Sticky error flags; clear has priority over a same-cycle set
   always_ff @(posedge i_clock) begin
      if (!i_rst_n) begin
         err_underrun_q <= 1'b0;
         err_frame_q    <= 1'b0;
      end else if (i_err_clr) begin
         err_underrun_q <= 1'b0;
         err_frame_q    <= 1'b0;
      end else begin
         if (load && !hold_full_q)             err_underrun_q <= 1'b1;
         if (ss_rise && (bit_cnt_q != '0))     err_frame_q    <= 1'b1;
      end
   end

   assign o_err_underrun = err_underrun_q;
   assign o_err_frame    = err_frame_q;
`endif

   assign o_spi_miso    = miso_q;
   assign o_spi_miso_oe = (state_q != StIdle);
   assign o_busy        = (state_q != StIdle);
   assign o_rx_data     = rx_data_q;
   assign o_rx_valid    = rx_valid_q;

endmodule
